// File: rtl/i2c_reg_ctrl_if.sv
// ==[ i2c_reg_ctrl_if : strobe and host bus bundle for i2c_reg_ctrl ]==
// ==[ rev 1.0 ]==
`default_nettype none

interface i2c_reg_ctrl_if #(
  parameter int AW = 4
);
  logic          i2c_act;
  logic          i2c_as;
  logic          i2c_ws;
  logic          i2c_rs;
  logic [7:0]    i2c_dat;
  logic [7:0]    i2c_rdat;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdat;
  logic [7:0]    host_rdat;
  logic          host_ack;
  logic          wr_irq;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] ptr;

  modport master (
    output i2c_act, i2c_as, i2c_ws, i2c_rs, i2c_dat,
    output host_req, host_we, host_addr, host_wdat,
    input  i2c_rdat, host_rdat, host_ack, wr_irq, wr_idx, ptr
  );

  modport slave (
    input  i2c_act, i2c_as, i2c_ws, i2c_rs, i2c_dat,
    input  host_req, host_we, host_addr, host_wdat,
    output i2c_rdat, host_rdat, host_ack, wr_irq, wr_idx, ptr
  );
endinterface

`default_nettype wire

// File: rtl/i2c_reg_ctrl.sv
// ==[ i2c_reg_ctrl : pointer-addressed 8-bit register bank behind i2c_slave ]==
// ==[ rev 1.0 ]==
`default_nettype none

module i2c_reg_ctrl #(
  parameter int         AW      = 4,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_reg_ctrl_if.slave    bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_ACC  = 2'd1,
    H_ACK  = 2'd2
  } hstate_t;

  hstate_t       state, state_nxt;
  logic [7:0]    bank     [DEPTH];
  logic [7:0]    bank_nxt [DEPTH];
  logic [AW-1:0] ptr_q, ptr_nxt;
  logic [7:0]    rdat_q, host_rdat_q;
  logic          wr_irq_q;
  logic [AW-1:0] wr_idx_q;
  logic          i2c_we;
  logic          host_commit;
  logic          host_capture;

  // A pointer load wins over a coincident write strobe; that write is dropped.
  always_comb begin
    i2c_we  = bus.i2c_ws && !bus.i2c_as;
    ptr_nxt = ptr_q;
    if (bus.i2c_as)
      ptr_nxt = bus.i2c_dat[AW-1:0];
    else if (bus.i2c_ws || bus.i2c_rs)
      ptr_nxt = ptr_q + 1'b1;
  end

  // The I2C strobe cannot be stalled, so a host write waits out any i2c_ws cycle.
  always_comb begin
    state_nxt    = state;
    host_commit  = 1'b0;
    host_capture = 1'b0;
    case (state)
      H_IDLE: if (bus.host_req) state_nxt = H_ACC;
      H_ACC: begin
        if (!(bus.host_we && bus.i2c_ws)) begin
          host_commit  = bus.host_we;
          host_capture = 1'b1;
          state_nxt    = H_ACK;
        end
      end
      H_ACK:   state_nxt = H_IDLE;
      default: state_nxt = H_IDLE;
    endcase
  end

  always_comb begin
    bank_nxt = bank;
    if (host_commit)
      bank_nxt[bus.host_addr] = bus.host_wdat;
    if (i2c_we)
      bank_nxt[ptr_q] = bus.i2c_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= H_IDLE;
      ptr_q       <= '0;
      rdat_q      <= RST_VAL;
      host_rdat_q <= 8'h00;
      wr_irq_q    <= 1'b0;
      wr_idx_q    <= '0;
      for (int i = 0; i < DEPTH; i++)
        bank[i] <= RST_VAL;
    end else begin
      state    <= state_nxt;
      ptr_q    <= ptr_nxt;
      // Pre-fetch sees this cycle's pointer and bank updates from both sides.
      rdat_q   <= bank_nxt[ptr_nxt];
      wr_irq_q <= i2c_we;
      if (i2c_we)
        wr_idx_q <= ptr_q;
      if (host_capture)
        host_rdat_q <= bank[bus.host_addr];
      for (int i = 0; i < DEPTH; i++)
        bank[i] <= bank_nxt[i];
    end
  end

  assign bus.ptr       = ptr_q;
  assign bus.i2c_rdat  = rdat_q;
  assign bus.host_rdat = host_rdat_q;
  assign bus.host_ack  = (state == H_ACK);
  assign bus.wr_irq    = wr_irq_q;
  assign bus.wr_idx    = wr_idx_q;
endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_ctrl.sv
// ==[ tb_i2c_reg_ctrl : directed scoreboard bench for i2c_reg_ctrl ]==
// ==[ rev 1.0 ]==
`default_nettype none

module tb_i2c_reg_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  i2c_reg_ctrl_if #(.AW(4)) bus ();

  i2c_reg_ctrl #(.AW(4), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       chk;
    logic [7:0] v;
  } hexp_t;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] wr_q [$];
  logic [7:0] rd_q [$];
  hexp_t      host_q [$];
  logic [7:0] m_bank [16];
  logic [3:0] m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = '0;
    for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
  endtask

  task automatic i2c_as_t(input logic [7:0] d);
    @(posedge clk) #1;
    bus.i2c_as  = 1'b1;
    bus.i2c_dat = d;
    m_ptr       = d[3:0];
    @(posedge clk) #1;
    bus.i2c_as  = 1'b0;
  endtask

  task automatic i2c_ws_t(input logic [7:0] d);
    @(posedge clk) #1;
    bus.i2c_ws  = 1'b1;
    bus.i2c_dat = d;
    wr_q.push_back(m_ptr);
    m_bank[m_ptr] = d;
    m_ptr++;
    @(posedge clk) #1;
    bus.i2c_ws = 1'b0;
    chk("wr_irq_after_ws", {31'd0, bus.wr_irq}, 32'd1);
  endtask

  task automatic i2c_rs_t();
    @(posedge clk) #1;
    bus.i2c_rs = 1'b1;
    rd_q.push_back(m_bank[m_ptr]);
    m_ptr++;
    @(posedge clk) #1;
    bus.i2c_rs = 1'b0;
  endtask

  // Cycle count is inclusive: the cycle req rises is 1, the ack cycle is the last.
  task automatic host_acc(input logic we, input logic [3:0] addr, input logic [7:0] d,
                          input int exp_cyc, input logic contend, input logic [7:0] cdat);
    int   cyc;
    logic got;
    @(posedge clk) #1;
    bus.host_req  = 1'b1;
    bus.host_we   = we;
    bus.host_addr = addr;
    bus.host_wdat = d;
    host_q.push_back('{chk: !we, v: m_bank[addr]});
    cyc = 1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk) #1;
      cyc++;
      bus.i2c_ws = contend && (cyc == 2);
      if (contend && cyc == 2) begin
        bus.i2c_dat = cdat;
        wr_q.push_back(m_ptr);
        m_bank[m_ptr] = cdat;
        m_ptr++;
      end
      if (bus.host_ack) got = 1'b1;
    end
    chk("host_latency", got ? cyc : 0, exp_cyc);
    if (we) m_bank[addr] = d;
    bus.host_req = 1'b0;
    bus.i2c_ws   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.wr_irq) begin
      if (wr_q.size() == 0) chk("wr_irq_spurious", 32'd1, 32'd0);
      else                  chk("wr_idx", {28'd0, bus.wr_idx}, {28'd0, wr_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.i2c_rs) begin
      if (rd_q.size() == 0) chk("rs_unexpected", 32'd1, 32'd0);
      else                  chk("i2c_rdat_at_rs", {24'd0, bus.i2c_rdat}, {24'd0, rd_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    hexp_t e;
    if (rst_n && bus.host_ack) begin
      if (host_q.size() == 0) chk("host_ack_spurious", 32'd1, 32'd0);
      else begin
        e = host_q.pop_front();
        if (e.chk) chk("host_rdat", {24'd0, bus.host_rdat}, {24'd0, e.v});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.i2c_act   = 1'b0;
    bus.i2c_as    = 1'b0;
    bus.i2c_ws    = 1'b0;
    bus.i2c_rs    = 1'b0;
    bus.i2c_dat   = 8'h00;
    bus.host_req  = 1'b0;
    bus.host_we   = 1'b0;
    bus.host_addr = 4'h0;
    bus.host_wdat = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk) #1;

    chk("rst_ptr",       {28'd0, bus.ptr},       32'h0);
    chk("rst_i2c_rdat",  {24'd0, bus.i2c_rdat},  32'h0);
    chk("rst_host_ack",  {31'd0, bus.host_ack},  32'h0);
    chk("rst_wr_irq",    {31'd0, bus.wr_irq},    32'h0);
    chk("rst_wr_idx",    {28'd0, bus.wr_idx},    32'h0);
    chk("rst_host_rdat", {24'd0, bus.host_rdat}, 32'h0);

    // Burst write wrapping past the top of the bank
    bus.i2c_act = 1'b1;
    i2c_as_t(8'h0E);
    i2c_ws_t(8'hA1);
    i2c_ws_t(8'hA2);
    i2c_ws_t(8'hA3);
    bus.i2c_act = 1'b0;
    chk("burst_wr_ptr", {28'd0, bus.ptr}, 32'd1);
    host_acc(1'b0, 4'd14, 8'h00, 3, 1'b0, 8'h00);
    host_acc(1'b0, 4'd15, 8'h00, 3, 1'b0, 8'h00);
    host_acc(1'b0, 4'd0,  8'h00, 3, 1'b0, 8'h00);

    // Burst read of host-preloaded registers
    host_acc(1'b1, 4'd3, 8'h11, 3, 1'b0, 8'h00);
    host_acc(1'b1, 4'd4, 8'h22, 3, 1'b0, 8'h00);
    host_acc(1'b1, 4'd5, 8'h33, 3, 1'b0, 8'h00);
    bus.i2c_act = 1'b1;
    i2c_as_t(8'h03);
    i2c_rs_t();
    i2c_rs_t();
    i2c_rs_t();
    bus.i2c_act = 1'b0;
    chk("burst_rd_ptr", {28'd0, bus.ptr}, 32'd6);

    // Host write stalled by an I2C write in its access cycle
    i2c_as_t(8'h02);
    host_acc(1'b1, 4'd2, 8'h5A, 4, 1'b1, 8'hC3);
    chk("contend_ptr", {28'd0, bus.ptr}, 32'd3);
    host_acc(1'b0, 4'd2, 8'h00, 3, 1'b0, 8'h00);

    // Host write to the pointed register refreshes the pre-fetch
    i2c_as_t(8'h07);
    host_acc(1'b1, 4'd7, 8'h99, 3, 1'b0, 8'h00);
    chk("prefetch_coherent", {24'd0, bus.i2c_rdat}, 32'h99);
    i2c_rs_t();
    chk("prefetch_ptr", {28'd0, bus.ptr}, 32'd8);

    // Reset while a host write sits in its access state
    @(posedge clk) #1;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b1;
    bus.host_addr = 4'd9;
    bus.host_wdat = 8'h77;
    @(posedge clk) #1;
    #2 rst_n = 1'b0;
    #1;
    bus.host_req = 1'b0;
    model_reset();
    chk("rstmid_host_ack", {31'd0, bus.host_ack}, 32'h0);
    chk("rstmid_ptr",      {28'd0, bus.ptr},      32'h0);
    chk("rstmid_i2c_rdat", {24'd0, bus.i2c_rdat}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    host_acc(1'b0, 4'd9, 8'h00, 3, 1'b0, 8'h00);
    host_acc(1'b0, 4'd7, 8'h00, 3, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("wr_q_drained",   wr_q.size(),   32'd0);
    chk("rd_q_drained",   rd_q.size(),   32'd0);
    chk("host_q_drained", host_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
